// File: rtl/mem_port_responder_pkg.sv
// mem_port_responder_pkg
//   Shared types and limits for the memory-port responder.
//   - state_e           : controller FSM states (INIT only used when
//                         MEM_PORT_RESPONDER_CLEAR_EN is defined)
//   - MAX_READ_LATENCY  : largest supported read latency
//   - MAX_WAIT_STATES   : largest supported post-access wait count
package mem_port_responder_pkg;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    WAIT = 2'd2
  } state_e;

  localparam int MAX_READ_LATENCY = 8;
  localparam int MAX_WAIT_STATES  = 15;

endpackage

// File: rtl/mem_port_if.sv
// mem_port_if
//   Request/response bundle between a memory client and a memory controller.
//   Ports (signals):
//     addr, data, byte_en, wr, rd : client -> controller request
//     q, available                : controller -> client read return
//     ready                       : controller accepts a request this cycle
//   Modports: controller (responder end), client (requester end).
interface mem_port_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] byte_en;
  logic                    wr;
  logic                    rd;
  logic [DATA_WIDTH-1:0]   q;
  logic                    available;
  logic                    ready;

  modport controller (
    input  addr, data, byte_en, wr, rd,
    output q, available, ready
  );

  modport client (
    output addr, data, byte_en, wr, rd,
    input  q, available, ready
  );

endinterface

// File: rtl/mem_port_responder_ram.sv
// mem_port_responder_ram
//   Single-port synchronous RAM, byte-lane write enables, 1-cycle read.
//   Ports:
//     clk, reset : clock; async active-high reset (read register only)
//     we, be     : write strobe and byte-lane enables
//     addr       : word address shared by read and write
//     wdata      : write data
//     re         : read strobe; rdata holds when re is low
//     rdata      : registered read data
module mem_port_responder_ram #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic                    re,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int BE_W  = DATA_WIDTH/8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Stage p0 -> p1: array read into the output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_port_responder.sv
// mem_port_responder
//   Controller end of mem_port_if backed by an internal byte-enabled RAM.
//   Emulates a slow controller: reads return READ_LATENCY cycles after
//   acceptance; ready drops for WAIT_STATES cycles after every access.
//   Ports:
//     clk   : system clock
//     reset : asynchronous, active-high reset
//     port  : mem_port_if.controller (addr/data/byte_en/wr/rd in,
//             q/available/ready out)
//   Optional build macro: MEM_PORT_RESPONDER_CLEAR_EN -- after reset the
//   RAM is zeroed one word per cycle before ready first rises.
module mem_port_responder
  import mem_port_responder_pkg::*;
#(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 2,
  parameter int WAIT_STATES  = 1
) (
  input  logic           clk,
  input  logic           reset,
  mem_port_if.controller port
);

  localparam int BE_W = DATA_WIDTH/8;

`ifdef MEM_PORT_RESPONDER_CLEAR_EN
  localparam state_e RESET_STATE = INIT;
`else
  localparam state_e RESET_STATE = IDLE;
`endif

  state_e     state_q, state_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       ready_q, ready_d;

  logic accept, rd_go, wr_go;

  logic                  ram_we;
  logic [BE_W-1:0]       ram_be;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // A simultaneous rd+wr is a write; the read half is dropped.
  assign accept = ready_q & (port.rd | port.wr);
  assign wr_go  = accept & port.wr;
  assign rd_go  = accept & port.rd & ~port.wr;

`ifdef MEM_PORT_RESPONDER_CLEAR_EN
  // Extra MSB: counts 0..DEPTH so the cycle after the last clear write is
  // still spent in INIT.
  logic [ADDR_WIDTH:0] clr_cnt_q, clr_cnt_d;
  logic                clearing;

  assign clearing = (state_q == INIT) && !clr_cnt_q[ADDR_WIDTH];

  always_comb begin
    clr_cnt_d = clr_cnt_q;
    if (clearing) clr_cnt_d = clr_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) clr_cnt_q <= '0;
    else       clr_cnt_q <= clr_cnt_d;
  end
`endif

  always_comb begin
    ram_we    = wr_go;
    ram_be    = port.byte_en;
    ram_addr  = port.addr;
    ram_wdata = port.data;
`ifdef MEM_PORT_RESPONDER_CLEAR_EN
    if (clearing) begin
      ram_we    = 1'b1;
      ram_be    = '1;
      ram_addr  = clr_cnt_q[ADDR_WIDTH-1:0];
      ram_wdata = '0;
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      INIT: begin
`ifdef MEM_PORT_RESPONDER_CLEAR_EN
        if (clr_cnt_q[ADDR_WIDTH]) state_d = IDLE;
`else
        state_d = IDLE;
`endif
      end
      IDLE: begin
        if (accept && (WAIT_STATES > 0)) begin
          state_d    = WAIT;
          wait_cnt_d = 4'(WAIT_STATES - 1);
        end
      end
      WAIT: begin
        if (wait_cnt_q == 4'd0) state_d = IDLE;
        else                    wait_cnt_d = wait_cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
    // Registered ready keeps it low throughout reset and drops it on the
    // same edge that accepts a request.
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RESET_STATE;
      wait_cnt_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      ready_q    <= ready_d;
    end
  end

  assign port.ready = ready_q;

  mem_port_responder_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .re    (rd_go),
    .rdata (ram_rdata)
  );

  // Stage p1..pN: valid shift chain; vld_p[0] pairs with the RAM output.
  logic [READ_LATENCY-1:0] vld_p;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= rd_go;
      for (int k = 1; k < READ_LATENCY; k++) vld_p[k] <= vld_p[k-1];
    end
  end

  assign port.available = vld_p[READ_LATENCY-1];

  generate
    if (READ_LATENCY == 1) begin : g_lat1
      assign port.q = ram_rdata;
    end else begin : g_latn
      // Stage p2..pN: data moves only alongside a valid, so the last stage
      // (q) holds between pulses.
      logic [DATA_WIDTH-1:0] dat_p [READ_LATENCY-1];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int k = 0; k < READ_LATENCY-1; k++) dat_p[k] <= '0;
        end else begin
          if (vld_p[0]) dat_p[0] <= ram_rdata;
          for (int k = 1; k < READ_LATENCY-1; k++) begin
            if (vld_p[k]) dat_p[k] <= dat_p[k-1];
          end
        end
      end

      assign port.q = dat_p[READ_LATENCY-2];
    end
  endgenerate

endmodule

// File: tb/tb_mem_port_responder.sv
module tb_mem_port_responder;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int RL_A  = 3;
  localparam int WS_A  = 0;
  localparam int RL_B  = 4;
  localparam int WS_B  = 2;
`ifdef MEM_PORT_RESPONDER_CLEAR_EN
  localparam int EXP_RISE = DEPTH + 1;
`else
  localparam int EXP_RISE = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  mem_port_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifa ();
  mem_port_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifb ();

  mem_port_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL_A), .WAIT_STATES(WS_A)
  ) dut_a (
    .clk  (clk),
    .reset(rst_a),
    .port (ifa.controller)
  );

  mem_port_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL_B), .WAIT_STATES(WS_B)
  ) dut_b (
    .clk  (clk),
    .reset(rst_b),
    .port (ifb.controller)
  );

  logic [31:0] model_a [DEPTH];
  logic [31:0] model_b [DEPTH];
  logic [31:0] exp_dq_a [$];
  logic [31:0] exp_dq_b [$];
  int          exp_cyc_a [$];
  int          exp_cyc_b [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard for port A: acceptance seen at negedge cyc=n happens on edge
  // n+1; its pulse is visible at the negedge with cyc = n + RL.
  always @(negedge clk) begin
    if (rst_a) begin
      exp_dq_a.delete();
      exp_cyc_a.delete();
`ifdef MEM_PORT_RESPONDER_CLEAR_EN
      for (int i = 0; i < DEPTH; i++) model_a[i] <= '0;
`endif
    end else begin
      if (ifa.available) begin
        if (exp_dq_a.size() == 0) begin
          check("a_unexpected_available", {31'b0, ifa.available}, 32'd0);
        end else begin
          check("a_rd_data", ifa.q, exp_dq_a.pop_front());
          check("a_rd_cycle", cyc, exp_cyc_a.pop_front());
        end
      end else if (exp_cyc_a.size() != 0 && exp_cyc_a[0] <= cyc) begin
        check("a_missing_available", {31'b0, ifa.available}, 32'd1);
        void'(exp_dq_a.pop_front());
        void'(exp_cyc_a.pop_front());
      end
      if (ifa.ready && (ifa.rd || ifa.wr)) begin
        if (ifa.wr) begin
          for (int i = 0; i < 4; i++)
            if (ifa.byte_en[i]) model_a[ifa.addr][8*i +: 8] <= ifa.data[8*i +: 8];
        end else begin
          exp_dq_a.push_back(model_a[ifa.addr]);
          exp_cyc_a.push_back(cyc + RL_A);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_b) begin
      exp_dq_b.delete();
      exp_cyc_b.delete();
`ifdef MEM_PORT_RESPONDER_CLEAR_EN
      for (int i = 0; i < DEPTH; i++) model_b[i] <= '0;
`endif
    end else begin
      if (ifb.available) begin
        if (exp_dq_b.size() == 0) begin
          check("b_unexpected_available", {31'b0, ifb.available}, 32'd0);
        end else begin
          check("b_rd_data", ifb.q, exp_dq_b.pop_front());
          check("b_rd_cycle", cyc, exp_cyc_b.pop_front());
        end
      end else if (exp_cyc_b.size() != 0 && exp_cyc_b[0] <= cyc) begin
        check("b_missing_available", {31'b0, ifb.available}, 32'd1);
        void'(exp_dq_b.pop_front());
        void'(exp_cyc_b.pop_front());
      end
      if (ifb.ready && (ifb.rd || ifb.wr)) begin
        if (ifb.wr) begin
          for (int i = 0; i < 4; i++)
            if (ifb.byte_en[i]) model_b[ifb.addr][8*i +: 8] <= ifb.data[8*i +: 8];
        end else begin
          exp_dq_b.push_back(model_b[ifb.addr]);
          exp_cyc_b.push_back(cyc + RL_B);
        end
      end
    end
  end

  task automatic drive(input int p, input bit r, input bit w, input logic [3:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    if (p == 0) begin
      ifa.rd = r; ifa.wr = w; ifa.addr = a; ifa.data = d; ifa.byte_en = be;
    end else begin
      ifb.rd = r; ifb.wr = w; ifb.addr = a; ifb.data = d; ifb.byte_en = be;
    end
  endtask

  // Holds the request until ready is seen, then releases it after the edge.
  task automatic req(input int p, input bit r, input bit w, input logic [3:0] a,
                     input logic [31:0] d, input logic [3:0] be);
    int n = 0;
    bit ok = 1'b0;
    drive(p, r, w, a, d, be);
    while (!ok && n < 60) begin
      @(negedge clk);
      ok = (p == 0) ? ifa.ready : ifb.ready;
      n++;
    end
    if (!ok) check("req_accept_timeout", {31'b0, ok}, 32'd1);
    @(posedge clk); #1;
    drive(p, 1'b0, 1'b0, a, d, be);
  endtask

  task automatic wait_ready(input int p);
    int n = 0;
    logic rdy;
    rdy = (p == 0) ? ifa.ready : ifb.ready;
    while (!rdy && n < 60) begin
      @(posedge clk); #1;
      rdy = (p == 0) ? ifa.ready : ifb.ready;
      n++;
    end
    check("wait_ready", {31'b0, rdy}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    rst_a = 1'b1;
    rst_b = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    repeat (3) @(posedge clk);
    #1;

    check("a_rst_ready", {31'b0, ifa.ready}, 32'd0);
    check("a_rst_available", {31'b0, ifa.available}, 32'd0);
    check("a_rst_q", ifa.q, 32'd0);
    check("b_rst_ready", {31'b0, ifb.ready}, 32'd0);
    check("b_rst_available", {31'b0, ifb.available}, 32'd0);
    check("b_rst_q", ifb.q, 32'd0);

    rst_a = 1'b0;
    rst_b = 1'b0;
    k = 0;
    while (!ifa.ready && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check("a_ready_rise_cycles", k, EXP_RISE);
    wait_ready(1);

`ifdef MEM_PORT_RESPONDER_CLEAR_EN
    for (int a = 0; a < DEPTH; a++) req(0, 1'b1, 1'b0, 4'(a), '0, '0);
`endif

    for (int a = 0; a < DEPTH; a++)
      req(0, 1'b0, 1'b1, 4'(a), 32'hA5000000 ^ (a * 32'h00010203), 4'hF);

    req(0, 1'b0, 1'b1, 4'd3, 32'hAABBCCDD, 4'hF);
    req(0, 1'b0, 1'b1, 4'd3, 32'h11223344, 4'b0101);
    req(0, 1'b1, 1'b0, 4'd3, '0, '0);

    // Back-to-back reads: one acceptance per cycle with no wait states.
    for (int a = 0; a < 8; a++) req(0, 1'b1, 1'b0, 4'(a), '0, '0);

    req(0, 1'b1, 1'b1, 4'd5, 32'h5A5A5A5A, 4'hF);
    req(0, 1'b1, 1'b0, 4'd5, '0, '0);
    req(0, 1'b0, 1'b1, 4'd6, 32'h12345678, 4'h0);
    req(0, 1'b1, 1'b0, 4'd6, '0, '0);
    repeat (8) @(posedge clk);
    #1;

    req(1, 1'b0, 1'b1, 4'd1, 32'hCAFEF00D, 4'hF);
    req(1, 1'b0, 1'b1, 4'd2, 32'h0BADBEEF, 4'hF);
    wait_ready(1);

    // rd held high: ready pattern 1,0,0 repeating with WAIT_STATES=2.
    drive(1, 1'b1, 1'b0, 4'd1, '0, '0);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("b_ready_pattern", {31'b0, ifb.ready}, (i % 3 == 0) ? 32'd1 : 32'd0);
    end
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, 4'd1, '0, '0);

    wait_ready(1);
    req(1, 1'b1, 1'b0, 4'd2, '0, '0);
    @(posedge clk); #1;
    rst_b = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("b_midrst_ready", {31'b0, ifb.ready}, 32'd0);
      check("b_midrst_available", {31'b0, ifb.available}, 32'd0);
      check("b_midrst_q", ifb.q, 32'd0);
    end
    @(posedge clk); #1;
    rst_b = 1'b0;
    wait_ready(1);
    req(1, 1'b1, 1'b0, 4'd2, '0, '0);

    repeat (10) @(posedge clk);
    #1;
    check("a_scoreboard_drained", exp_dq_a.size(), 32'd0);
    check("b_scoreboard_drained", exp_dq_b.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
